// File: rtl/mem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus, fed by a TX FIFO.
// Optional runtime divisor register: define UART_TX_DIV_REG_EN.
module mem_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int unsigned CLK_DIV    = 417,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        tx
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] DIV_RESET = DW'(CLK_DIV);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_ready;
    logic [31:0]     r_rdata;
    logic            r_tx;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic [7:0]      r_shift;
    logic [2:0]      r_bit_idx;
    logic [DW-1:0]   r_cnt;
    logic [DW-1:0]   r_bit_div;
    logic [DW-1:0]   w_div_cfg;

    logic            w_sel;
    logic [1:0]      w_reg;
    logic            w_is_wr;
    logic            w_push_req;
    logic            w_can_push;
    logic            w_push;
    logic            w_pop;
    logic            w_ack;
    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic            w_bit_end;
    logic            w_tx_next;
    logic [31:0]     w_rdata;
    logic            w_unused_bits;

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign tx        = r_tx;

    assign w_unused_bits = &{1'b0, mem_addr[1:0], mem_wdata[31:8]};

    // Bus decode; a DATA write that cannot push stalls until a slot frees.
    assign w_sel      = mem_valid & (mem_addr[31:4] == BASE_ADDR[31:4]) & ~r_ready;
    assign w_reg      = mem_addr[3:2];
    assign w_is_wr    = |mem_wstrb;
    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == CW'(0));
    assign w_busy     = (r_state != S_IDLE);
    assign w_push_req = w_sel & w_is_wr & (w_reg == 2'd0) & mem_wstrb[0];
    assign w_can_push = ~w_full | w_pop;
    assign w_push     = w_push_req & w_can_push;
    assign w_ack      = w_sel & ~(w_push_req & ~w_can_push);

`ifdef UART_TX_DIV_REG_EN
    logic [DW-1:0] r_div_cfg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cfg <= DIV_RESET;
        end else if (w_sel && w_is_wr && (w_reg == 2'd2)) begin
            r_div_cfg <= (mem_wdata[15:0] < 16'd2) ? 16'd2 : mem_wdata[15:0];
        end
    end

    assign w_div_cfg = r_div_cfg;
`else
    assign w_div_cfg = DIV_RESET;
`endif

    always_comb begin
        w_rdata = '0;
        if (!w_is_wr) begin
            case (w_reg)
                2'd1: w_rdata = {16'h0000, 8'(r_count), 5'b00000, w_empty, w_full, w_busy};
`ifdef UART_TX_DIV_REG_EN
                2'd2: w_rdata = {16'h0000, w_div_cfg};
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    // Registered one-cycle acknowledge; rdata is zero whenever not acking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_ack;
            r_rdata <= w_ack ? w_rdata : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= AW'(r_wptr + 1'b1);
            if (w_pop)  r_rptr <= AW'(r_rptr + 1'b1);
            case ({w_push, w_pop})
                2'b10:   r_count <= CW'(r_count + 1'b1);
                2'b01:   r_count <= CW'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Bit timer; the divisor is relatched at every bit boundary.
    assign w_bit_end = (r_state != S_IDLE) && (r_cnt == DW'(r_bit_div - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_div <= DIV_RESET;
        end else if ((r_state == S_IDLE) || w_bit_end) begin
            r_cnt     <= '0;
            r_bit_div <= w_div_cfg;
        end else begin
            r_cnt     <= DW'(r_cnt + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rptr];
            r_bit_idx <= '0;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= 3'(r_bit_idx + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_next = S_START;
            S_START: if (w_bit_end) w_state_next = S_DATA;
            S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_bit_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        w_tx_next = 1'b1;
        case (r_state)
            S_IDLE:  w_pop     = ~w_empty;
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = r_shift[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
        end
    end

endmodule
